// File: rtl/cpu_oci_dct_packer_pkg.sv
// Shared sizing and FSM state type for the OCI trace-atom packer.
// Contents:
//   ATOM_W - bits per trace atom
//   SLOTS  - atoms per frame
//   BUF_W  - frame width, ATOM_W*SLOTS
//   CNT_W  - width of slot counts (must hold SLOTS)
//   dct_state_e - packer FSM states
package cpu_oci_dct_pkg;

    localparam int unsigned ATOM_W = 2;
    localparam int unsigned SLOTS  = 15;
    localparam int unsigned BUF_W  = ATOM_W * SLOTS;
    localparam int unsigned CNT_W  = 4;

    typedef enum logic [1:0] {
        StAccum,
        StPend,
        StDrain,
        StDone
    } dct_state_e;

endpackage

// File: rtl/cpu_oci_dct_packer_if.sv
// Closed-frame valid/ready channel from the packer to the OCI monitor.
// Signals:
//   frame_valid - frame held (master -> slave)
//   frame_ready - downstream accepts the frame (slave -> master)
//   frame_data  - closed frame, atoms packed LSB-first
//   frame_count - number of valid atoms in frame_data, 1..SLOTS
// Modports: master (packer side), slave (monitor side).
interface cpu_oci_dct_packer_if;
    import cpu_oci_dct_pkg::*;

    logic             frame_valid;
    logic             frame_ready;
    logic [BUF_W-1:0] frame_data;
    logic [CNT_W-1:0] frame_count;

    modport master (
        output frame_valid,
        output frame_data,
        output frame_count,
        input  frame_ready
    );

    modport slave (
        input  frame_valid,
        input  frame_data,
        input  frame_count,
        output frame_ready
    );

endinterface

// File: rtl/cpu_oci_dct_outreg.sv
// One-deep valid/ready holding register for closed frames.
// Ports:
//   clk, reset_n  - clock, asynchronous active-low reset
//   load          - capture load_data/load_count (only when accept is high)
//   load_data     - frame to capture
//   load_count    - atom count of the frame to capture
//   ready         - downstream accepts the held frame
//   accept        - register is empty or transferring this cycle
//   valid         - frame held
//   data, count   - held frame and its atom count, stable while stalled
module cpu_oci_dct_outreg
    import cpu_oci_dct_pkg::*;
(
    input  logic             clk,
    input  logic             reset_n,
    input  logic             load,
    input  logic [BUF_W-1:0] load_data,
    input  logic [CNT_W-1:0] load_count,
    input  logic             ready,
    output logic             accept,
    output logic             valid,
    output logic [BUF_W-1:0] data,
    output logic [CNT_W-1:0] count
);

    logic             valid_q;
    logic [BUF_W-1:0] data_q;
    logic [CNT_W-1:0] count_q;

    assign accept = !valid_q || ready;
    assign valid  = valid_q;
    assign data   = data_q;
    assign count  = count_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            count_q <= '0;
        end else if (load) begin
            valid_q <= 1'b1;
            data_q  <= load_data;
            count_q <= load_count;
        end else if (valid_q && ready) begin
            valid_q <= 1'b0;
        end
    end

endmodule

// File: rtl/cpu_oci_dct_packer.sv
// Trace-atom packer in front of the OCI test-bench monitor. Packs ATOM_W-bit
// atoms LSB-first into a SLOTS-slot accumulator, hands closed frames to a
// one-deep output register, and turns test_ending into a sticky
// test_has_ended once all trace has drained.
// Ports:
//   clk, reset_n       - clock, asynchronous active-low reset
//   atom_valid, atom   - incoming trace atom, no backpressure
//   flush              - close the partial frame
//   test_ending        - end-of-test request, level or pulse (latched)
//   frame              - closed-frame valid/ready channel (master)
//   dct_buffer         - live accumulator contents
//   dct_count          - live accumulator slot count
//   overflow           - sticky, an atom was dropped
//   test_has_ended     - sticky, drain complete
//   drop_count         - saturating dropped-atom count, only with
//                        DCT_PACKER_DROP_CNT_EN defined
module cpu_oci_dct_packer
    import cpu_oci_dct_pkg::*;
(
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 atom_valid,
    input  logic [ATOM_W-1:0]    atom,
    input  logic                 flush,
    input  logic                 test_ending,
    cpu_oci_dct_packer_if.master frame,
    output logic [BUF_W-1:0]     dct_buffer,
    output logic [CNT_W-1:0]     dct_count,
    output logic                 overflow,
    output logic                 test_has_ended
`ifdef DCT_PACKER_DROP_CNT_EN
    ,
    output logic [7:0]           drop_count
`endif
);

    localparam logic [CNT_W-1:0] FullCnt = CNT_W'(SLOTS);

    dct_state_e       st_q;
    logic [BUF_W-1:0] buf_q;
    logic [CNT_W-1:0] cnt_q;
    logic             te_q;
    logic             ovf_q;
    logic             done_q;

    logic             te_seen, te_first, take, close, drop;
    logic [BUF_W-1:0] nbuf;
    logic [CNT_W-1:0] ncnt;
    logic             load, accept, out_valid;
    logic [BUF_W-1:0] load_data, out_data;
    logic [CNT_W-1:0] load_count, out_count;

    always_comb begin
        te_seen    = te_q | test_ending;
        te_first   = test_ending & ~te_q;
        // Atoms arriving with or after test_ending are ignored, not dropped.
        take       = atom_valid & ~te_seen & (st_q == StAccum);
        drop       = atom_valid & ~te_seen & (st_q == StPend);
        nbuf       = buf_q;
        if (take) begin
            nbuf = buf_q | (BUF_W'(atom) << (cnt_q * ATOM_W));
        end
        ncnt       = cnt_q + CNT_W'(take);
        close      = 1'b0;
        load       = 1'b0;
        load_data  = buf_q;
        load_count = cnt_q;
        unique case (st_q)
            StAccum: begin
                // Same-cycle atom is packed first, then the frame closes.
                close = (take && ncnt == FullCnt) ||
                        ((flush || te_first) && ncnt != '0);
                load       = close & accept;
                load_data  = nbuf;
                load_count = ncnt;
            end
            StPend:  load = accept;
            StDrain: load = (cnt_q != '0) & accept;
            StDone:  load = 1'b0;
        endcase
    end

    cpu_oci_dct_outreg u_outreg (
        .clk        (clk),
        .reset_n    (reset_n),
        .load       (load),
        .load_data  (load_data),
        .load_count (load_count),
        .ready      (frame.frame_ready),
        .accept     (accept),
        .valid      (out_valid),
        .data       (out_data),
        .count      (out_count)
    );

    assign frame.frame_valid = out_valid;
    assign frame.frame_data  = out_data;
    assign frame.frame_count = out_count;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            st_q   <= StAccum;
            buf_q  <= '0;
            cnt_q  <= '0;
            te_q   <= 1'b0;
            ovf_q  <= 1'b0;
            done_q <= 1'b0;
        end else begin
            if (test_ending) te_q <= 1'b1;
            if (drop) ovf_q <= 1'b1;
            unique case (st_q)
                StAccum: begin
                    if (load) begin
                        buf_q <= '0;
                        cnt_q <= '0;
                        st_q  <= te_seen ? StDrain : StAccum;
                    end else begin
                        buf_q <= nbuf;
                        cnt_q <= ncnt;
                        if (close)        st_q <= StPend;
                        else if (te_seen) st_q <= StDrain;
                    end
                end
                StPend: begin
                    if (load) begin
                        buf_q <= '0;
                        cnt_q <= '0;
                        st_q  <= te_seen ? StDrain : StAccum;
                    end
                end
                StDrain: begin
                    if (load) begin
                        buf_q <= '0;
                        cnt_q <= '0;
                    end else if (cnt_q == '0 && !out_valid) begin
                        st_q   <= StDone;
                        done_q <= 1'b1;
                    end
                end
                StDone: done_q <= 1'b1;
            endcase
        end
    end

`ifdef DCT_PACKER_DROP_CNT_EN
    logic [7:0] drop_cnt_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            drop_cnt_q <= '0;
        end else if (drop && drop_cnt_q != 8'hff) begin
            drop_cnt_q <= drop_cnt_q + 8'd1;
        end
    end

    assign drop_count = drop_cnt_q;
`endif

    assign dct_buffer     = buf_q;
    assign dct_count      = cnt_q;
    assign overflow       = ovf_q;
    assign test_has_ended = done_q;

endmodule

// File: tb/tb_cpu_oci_dct_packer.sv
// Directed self-checking bench for cpu_oci_dct_packer. Inputs change just
// after the falling edge; outputs are sampled on the falling edge.
module tb_cpu_oci_dct_packer;
    import cpu_oci_dct_pkg::*;

    logic              clk;
    logic              reset_n;
    logic              atom_valid;
    logic [ATOM_W-1:0] atom;
    logic              flush;
    logic              test_ending;
    logic [BUF_W-1:0]  dct_buffer;
    logic [CNT_W-1:0]  dct_count;
    logic              overflow;
    logic              test_has_ended;
`ifdef DCT_PACKER_DROP_CNT_EN
    logic [7:0]        drop_count;
`endif

    int passed = 0;
    int failed = 0;
    int total  = 0;

    cpu_oci_dct_packer_if frame_if ();

    cpu_oci_dct_packer dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .atom_valid     (atom_valid),
        .atom           (atom),
        .flush          (flush),
        .test_ending    (test_ending),
        .frame          (frame_if),
        .dct_buffer     (dct_buffer),
        .dct_count      (dct_count),
        .overflow       (overflow),
        .test_has_ended (test_has_ended)
`ifdef DCT_PACKER_DROP_CNT_EN
        ,
        .drop_count     (drop_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: got %0h, want %0h", name, obs, exp);
        end
    endtask

    // Apply one cycle of inputs, then return at the next falling edge.
    task automatic put(input logic v, input logic [1:0] a, input logic f, input logic te);
        atom_valid  = v;
        atom        = a;
        flush       = f;
        test_ending = te;
        @(negedge clk);
    endtask

    task automatic idle();
        put(1'b0, 2'd0, 1'b0, 1'b0);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, " dct_count"},   32'(dct_count), 32'h0);
        chk({tag, " dct_buffer"},  32'(dct_buffer), 32'h0);
        chk({tag, " frame_valid"}, 32'(frame_if.frame_valid), 32'h0);
        chk({tag, " frame_data"},  32'(frame_if.frame_data), 32'h0);
        chk({tag, " frame_count"}, 32'(frame_if.frame_count), 32'h0);
        chk({tag, " overflow"},    32'(overflow), 32'h0);
        chk({tag, " ended"},       32'(test_has_ended), 32'h0);
`ifdef DCT_PACKER_DROP_CNT_EN
        chk({tag, " drop_count"},  32'(drop_count), 32'h0);
`endif
    endtask

    initial begin
        reset_n              = 1'b0;
        atom_valid           = 1'b0;
        atom                 = 2'd0;
        flush                = 1'b0;
        test_ending          = 1'b0;
        frame_if.frame_ready = 1'b0;
        #3;
        chk_all_zero("reset");
        @(negedge clk);
        reset_n = 1'b1;
        frame_if.frame_ready = 1'b1;

        // 15 atoms of 01 back-to-back, downstream ready.
        put(1'b1, 2'b01, 1'b0, 1'b0);
        chk("t1 latency count", 32'(dct_count), 32'd1);
        chk("t1 latency buf", 32'(dct_buffer), 32'h1);
        for (int i = 0; i < 13; i++) put(1'b1, 2'b01, 1'b0, 1'b0);
        chk("t1 count14", 32'(dct_count), 32'd14);
        chk("t1 buf14", 32'(dct_buffer), 32'h05555555);
        chk("t1 no frame yet", 32'(frame_if.frame_valid), 32'h0);
        put(1'b1, 2'b01, 1'b0, 1'b0);
        chk("t1 frame_valid", 32'(frame_if.frame_valid), 32'h1);
        chk("t1 frame_data", 32'(frame_if.frame_data), 32'h15555555);
        chk("t1 frame_count", 32'(frame_if.frame_count), 32'd15);
        chk("t1 acc cleared cnt", 32'(dct_count), 32'd0);
        chk("t1 acc cleared buf", 32'(dct_buffer), 32'h0);
        idle();
        chk("t1 transferred", 32'(frame_if.frame_valid), 32'h0);

        // Atoms 3,2,1 then flush with atom 0: slot k holds the k-th atom.
        put(1'b1, 2'd3, 1'b0, 1'b0);
        put(1'b1, 2'd2, 1'b0, 1'b0);
        put(1'b1, 2'd1, 1'b0, 1'b0);
        chk("t2a partial buf", 32'(dct_buffer), 32'h1b);
        chk("t2a partial cnt", 32'(dct_count), 32'd3);
        put(1'b1, 2'd0, 1'b1, 1'b0);
        chk("t2a frame_valid", 32'(frame_if.frame_valid), 32'h1);
        chk("t2a frame_data", 32'(frame_if.frame_data), 32'h1b);
        chk("t2a frame_count", 32'(frame_if.frame_count), 32'd4);
        chk("t2a acc cleared", 32'(dct_count), 32'd0);
        idle();

        // Atoms 1,2,3 then flush with atom 0.
        put(1'b1, 2'd1, 1'b0, 1'b0);
        put(1'b1, 2'd2, 1'b0, 1'b0);
        put(1'b1, 2'd3, 1'b0, 1'b0);
        put(1'b1, 2'd0, 1'b1, 1'b0);
        chk("t2b frame_data", 32'(frame_if.frame_data), 32'h39);
        chk("t2b frame_count", 32'(frame_if.frame_count), 32'd4);
        idle();
        chk("t2b transferred", 32'(frame_if.frame_valid), 32'h0);

        // Flush on an empty accumulator is a no-op.
        put(1'b0, 2'd0, 1'b1, 1'b0);
        chk("t6 no frame", 32'(frame_if.frame_valid), 32'h0);
        chk("t6 count", 32'(dct_count), 32'd0);
        idle();
        chk("t6 still no frame", 32'(frame_if.frame_valid), 32'h0);

        // Flush with an atom at count 0 gives a one-atom frame.
        put(1'b1, 2'd2, 1'b1, 1'b0);
        chk("t6b frame_valid", 32'(frame_if.frame_valid), 32'h1);
        chk("t6b frame_data", 32'(frame_if.frame_data), 32'h2);
        chk("t6b frame_count", 32'(frame_if.frame_count), 32'd1);
        idle();

        // Stalled downstream: frame in output, second frame in PEND, drops.
        frame_if.frame_ready = 1'b0;
        for (int i = 0; i < 15; i++) put(1'b1, 2'b11, 1'b0, 1'b0);
        chk("t3 first frame valid", 32'(frame_if.frame_valid), 32'h1);
        chk("t3 first frame data", 32'(frame_if.frame_data), 32'h3fffffff);
        for (int i = 0; i < 15; i++) put(1'b1, 2'b11, 1'b0, 1'b0);
        chk("t3 pend count", 32'(dct_count), 32'd15);
        chk("t3 pend buf", 32'(dct_buffer), 32'h3fffffff);
        chk("t3 no overflow yet", 32'(overflow), 32'h0);
        put(1'b1, 2'b11, 1'b0, 1'b0);
        put(1'b1, 2'b01, 1'b0, 1'b0);
        chk("t3 overflow", 32'(overflow), 32'h1);
        chk("t3 frozen buf", 32'(dct_buffer), 32'h3fffffff);
`ifdef DCT_PACKER_DROP_CNT_EN
        chk("t3 drop_count", 32'(drop_count), 32'd2);
`endif
        put(1'b0, 2'd0, 1'b1, 1'b0);
        chk("t3 flush ignored in pend", 32'(dct_count), 32'd15);
        chk("t3 held valid", 32'(frame_if.frame_valid), 32'h1);
        chk("t3 held count", 32'(frame_if.frame_count), 32'd15);
        frame_if.frame_ready = 1'b1;
        idle();
        chk("t3 second frame valid", 32'(frame_if.frame_valid), 32'h1);
        chk("t3 second frame data", 32'(frame_if.frame_data), 32'h3fffffff);
        chk("t3 pend moved", 32'(dct_count), 32'd0);
        idle();
        chk("t3 both delivered", 32'(frame_if.frame_valid), 32'h0);
        put(1'b1, 2'b01, 1'b0, 1'b0);
        chk("t3 back to accum", 32'(dct_count), 32'd1);

        // Asynchronous reset mid-frame.
        for (int i = 0; i < 6; i++) put(1'b1, 2'b01, 1'b0, 1'b0);
        chk("t5 mid count", 32'(dct_count), 32'd7);
        #2 reset_n = 1'b0;
        #1;
        chk_all_zero("t5 midframe");
        @(negedge clk);
        reset_n = 1'b1;
        put(1'b1, 2'd2, 1'b0, 1'b0);
        chk("t5 resume count", 32'(dct_count), 32'd1);
        chk("t5 resume buf", 32'(dct_buffer), 32'h2);

        // Asynchronous reset mid-PEND.
        put(1'b0, 2'd0, 1'b1, 1'b0);
        idle();
        frame_if.frame_ready = 1'b0;
        for (int i = 0; i < 31; i++) put(1'b1, 2'b01, 1'b0, 1'b0);
        chk("t5 pend count", 32'(dct_count), 32'd15);
        chk("t5 pend overflow", 32'(overflow), 32'h1);
        #2 reset_n = 1'b0;
        #1;
        chk_all_zero("t5 midpend");
        @(negedge clk);
        reset_n = 1'b1;
        frame_if.frame_ready = 1'b1;
        put(1'b1, 2'd3, 1'b0, 1'b0);
        chk("t5 post pend count", 32'(dct_count), 32'd1);
        chk("t5 post pend no frame", 32'(frame_if.frame_valid), 32'h0);
        put(1'b0, 2'd0, 1'b1, 1'b0);
        idle();

        // test_ending pulse with a 5-atom residue, downstream stalled.
        frame_if.frame_ready = 1'b0;
        for (int i = 0; i < 5; i++) put(1'b1, 2'b10, 1'b0, 1'b0);
        chk("t4 residue buf", 32'(dct_buffer), 32'h2aa);
        put(1'b0, 2'd0, 1'b0, 1'b1);
        chk("t4 frame_valid", 32'(frame_if.frame_valid), 32'h1);
        chk("t4 frame_data", 32'(frame_if.frame_data), 32'h2aa);
        chk("t4 frame_count", 32'(frame_if.frame_count), 32'd5);
        for (int i = 0; i < 3; i++) put(1'b1, 2'b01, 1'b0, 1'b0);
        chk("t4 atoms ignored", 32'(dct_count), 32'd0);
        chk("t4 not a drop", 32'(overflow), 32'h0);
        chk("t4 held data", 32'(frame_if.frame_data), 32'h2aa);
        chk("t4 not ended yet", 32'(test_has_ended), 32'h0);
        frame_if.frame_ready = 1'b1;
        for (int i = 0; i < 10 && !test_has_ended; i++) idle();
        chk("t4 ended", 32'(test_has_ended), 32'h1);
        chk("t4 drained", 32'(frame_if.frame_valid), 32'h0);
        put(1'b1, 2'b11, 1'b1, 1'b0);
        put(1'b1, 2'b11, 1'b0, 1'b1);
        idle();
        chk("t4 ended sticky", 32'(test_has_ended), 32'h1);
        chk("t4 done no frame", 32'(frame_if.frame_valid), 32'h0);
        chk("t4 done count", 32'(dct_count), 32'd0);
        chk("t4 done overflow", 32'(overflow), 32'h0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
